// File: rtl/fetch_prefetch_pkg.sv
// Shared types and constants for the fetch/prefetch stage.
// Holds no logic and adds no latency. It has no backpressure behaviour of its own.
// Contents: XLEN, INSTR_BYTES, the RESET_PC default, fetch_entry_t and a PC-alignment helper.
package fetch_prefetch_pkg;

    localparam int XLEN        = 32;
    localparam int INSTR_BYTES = 4;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = '0;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    // Fetch only ever addresses whole words, so the low two PC bits are cleared.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return pc & ~XLEN'(3);
    endfunction

endpackage

// File: rtl/fetch_prefetch_if.sv
// Bus bundle between fetch and its neighbours: execute (redirect), the loader and decode.
// The interface itself adds no latency. Decode pushes back through next_stalled, and fetch reports a full queue on stalled.
// Ports: redirect/redirect_pc, load_we/load_addr/load_data, instr/instr_pc/valid/stalled (out of fetch), next_stalled (into fetch).
interface fetch_prefetch_if #(
    parameter int IMEM_AW = 8
);
    import fetch_prefetch_pkg::*;

    logic               redirect;
    logic [XLEN-1:0]    redirect_pc;
    logic               load_we;
    logic [IMEM_AW-1:0] load_addr;
    logic [XLEN-1:0]    load_data;
    logic [XLEN-1:0]    instr;
    logic [XLEN-1:0]    instr_pc;
    logic               valid;
    logic               stalled;
    logic               next_stalled;

    modport master (
        output redirect, redirect_pc, load_we, load_addr, load_data, next_stalled,
        input  instr, instr_pc, valid, stalled
    );

    modport slave (
        input  redirect, redirect_pc, load_we, load_addr, load_data, next_stalled,
        output instr, instr_pc, valid, stalled
    );

endinterface

// File: rtl/fetch_prefetch_queue.sv
// Synchronous FIFO of fetch_entry_t with push, pop, flush and an occupancy count.
// A pushed entry is visible at the head on the cycle after the push edge.
// There is no internal backpressure: the producer must never push while full. A pop when empty is ignored.
// Ports: i_clk, i_rst (sync, active-high), i_flush, i_push/i_push_dat, i_pop, o_head_dat, o_count, o_empty.
module fetch_prefetch_queue
    import fetch_prefetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  fetch_entry_t             i_push_dat,
    input  logic                     i_pop,
    output fetch_entry_t             o_head_dat,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_empty
);
    localparam int PW = $clog2(DEPTH);

    fetch_entry_t  r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW:0]   r_count;
    logic          w_do_pop;

    assign w_do_pop = i_pop && (r_count != '0);

    // Storage is not reset. Only entries below r_count are ever presented.
    always_ff @(posedge i_clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_push_dat;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({i_push, w_do_pop})
                2'b10:   r_count <= r_count + (PW+1)'(1);
                2'b01:   r_count <= r_count - (PW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head_dat = r_mem[r_rd_ptr];
    assign o_count    = r_count;
    assign o_empty    = (r_count == '0);

endmodule

// File: rtl/fetch_prefetch.sv
// Fetch stage: owns the PC, reads a synchronous IMEM and queues {pc, instr} for decode.
// A word reaches decode two edges after its address is issued: one edge for the read and one for the push.
// Decode stalls with next_stalled. Fetch stops issuing once queue count plus the in-flight word reaches QUEUE_DEPTH, and reports stalled when full.
// Ports: i_clk, i_rstn (sync, active-high reset), bus (fetch_prefetch_if.slave).
module fetch_prefetch
    import fetch_prefetch_pkg::*;
#(
    parameter int              IMEM_DEPTH  = 256,
    parameter int              QUEUE_DEPTH = 4,
    parameter logic [XLEN-1:0] RESET_PC    = RESET_PC_DEFAULT
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    fetch_prefetch_if.slave  bus
);
    localparam int AW = $clog2(IMEM_DEPTH);
    localparam int CW = $clog2(QUEUE_DEPTH) + 1;
    localparam logic [CW-1:0] QD_FULL   = CW'(QUEUE_DEPTH);
    localparam logic [CW:0]   QD_CREDIT = (CW+1)'(QUEUE_DEPTH);

    logic [XLEN-1:0] r_mem [IMEM_DEPTH];
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_rd_pc;
    logic [XLEN-1:0] r_rd_data;
    logic            r_inflight;

    logic [AW-1:0]   w_rd_idx;
    logic [CW-1:0]   w_count;
    logic            w_empty;
    logic            w_issue;
    logic            w_push;
    logic            w_pop;
    fetch_entry_t    w_push_dat;
    fetch_entry_t    w_head;

    // Upper PC bits are ignored, so fetch wraps modulo IMEM_DEPTH words.
    assign w_rd_idx = r_pc[AW+1:2];

    // Credit check: the in-flight word already owns a slot, so a returning word always fits.
    assign w_issue = !bus.redirect &&
                     (({1'b0, w_count} + {{CW{1'b0}}, r_inflight}) < QD_CREDIT);

    // A redirect on the return edge kills the in-flight word.
    assign w_push = r_inflight && !bus.redirect;
    assign w_pop  = !w_empty && !bus.next_stalled;

    always_ff @(posedge i_clk) begin
        if (i_rstn) begin
            r_pc       <= align_pc(RESET_PC);
            r_inflight <= 1'b0;
        end else if (bus.redirect) begin
            r_pc       <= align_pc(bus.redirect_pc);
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_pc <= r_pc + XLEN'(INSTR_BYTES);
            end
        end
    end

    // The read samples the array before the same-edge load write lands, so the old word is returned.
    // r_rd_pc/r_rd_data are qualified by r_inflight, so they need no reset.
    always_ff @(posedge i_clk) begin
        if (bus.load_we) begin
            r_mem[bus.load_addr] <= bus.load_data;
        end
        r_rd_data <= r_mem[w_rd_idx];
        r_rd_pc   <= r_pc;
    end

    assign w_push_dat.pc    = r_rd_pc;
    assign w_push_dat.instr = r_rd_data;

    fetch_prefetch_queue #(
        .DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .i_clk      (i_clk),
        .i_rst      (i_rstn),
        .i_flush    (bus.redirect),
        .i_push     (w_push),
        .i_push_dat (w_push_dat),
        .i_pop      (w_pop),
        .o_head_dat (w_head),
        .o_count    (w_count),
        .o_empty    (w_empty)
    );

    assign bus.valid    = !w_empty;
    assign bus.stalled  = (w_count == QD_FULL);
    assign bus.instr    = w_empty ? '0 : w_head.instr;
    assign bus.instr_pc = w_empty ? '0 : w_head.pc;

endmodule
